// File: rtl/serial_tx_piso_pkg.sv
// Shared FSM state encoding and bit-counter sizing for the serial_tx_piso transmitter.
package serial_tx_piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Counter must reach WIDTH+1 (parity slot) without wrapping.
  function automatic int cntWidth(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit parallel-load, right-shift register; bit0_o is bit 0 of the value about to be
// registered, so the caller can register it in the same cycle as the load or shift.
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             bit0_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = din_i;
    end else if (shift_en_i) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit0_o = shreg_d[0];

endmodule

// File: rtl/serial_tx_piso.sv
// LSB-first parallel-in/serial-out transmitter with tx_en qualifier and done pulse.
// Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
module serial_tx_piso
  import serial_tx_piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             tx,
  output logic             tx_en,
  output logic             done
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic            txEn_q, txEn_d;
  logic            done_q, done_d;
  logic            shLoad, shEn, shBit;
`ifdef SERIAL_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Load/shift strobes kept outside the FSM block so shBit never feeds back into it.
  assign shLoad = (state_q == IDLE) && load;
  assign shEn   = (state_q == SHIFT) && (cnt_q < LAST);

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .load_i     (shLoad),
    .shift_en_i (shEn),
    .din_i      (din),
    .bit0_o     (shBit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = 1'b0;
    txEn_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load) begin
          tx_d    = shBit;
          txEn_d  = 1'b1;
          cnt_d   = CW'(1);
          state_d = SHIFT;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q < LAST) begin
          tx_d   = shBit;
          txEn_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
`ifdef SERIAL_TX_PARITY_EN
        end else if (cnt_q == LAST) begin
          tx_d   = parity_q;
          txEn_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
`endif
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_q     <= 1'b0;
      txEn_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      txEn_q   <= txEn_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign tx    = tx_q;
  assign tx_en = txEn_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Scoreboard bench for serial_tx_piso: each accepted load queues the expected per-cycle
// {tx, tx_en, done, ready} frame, popped and compared one cycle at a time.
module tb_serial_tx_piso;

  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME = W + 3;
`else
  localparam int FRAME = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         ready, tx, tx_en, done;

  int checks = 0;
  int errors = 0;

  logic [3:0] expQ[$];

  always #5 clk = ~clk;

  serial_tx_piso #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .din     (din),
    .ready   (ready),
    .tx      (tx),
    .tx_en   (tx_en),
    .done    (done)
  );

  // Expected outputs after each edge of one word, starting with the load edge.
  task automatic pushFrame(input logic [W-1:0] d);
    for (int k = 0; k < W; k++) expQ.push_back({d[k], 1'b1, 1'b0, 1'b0});
`ifdef SERIAL_TX_PARITY_EN
    expQ.push_back({^d, 1'b1, 1'b0, 1'b0});
`endif
    expQ.push_back(4'b0010);
    expQ.push_back(4'b0001);
  endtask

  // An empty queue means the transmitter is idle, so a pending load is accepted.
  task automatic stepCycle();
    if (reset_n && load && expQ.size() == 0) pushFrame(din);
    @(posedge clk);
    #1;
    if (!reset_n) expQ.delete();
  endtask

  function automatic logic [3:0] popExp();
    if (expQ.size() == 0) return 4'b0001;
    return expQ.pop_front();
  endfunction

  task automatic test_reset();
    logic [3:0] obs, exp;
    reset_n = 1'b0;
    load = 1'b0;
    din = '0;
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      obs = {tx, tx_en, done, ready};
      checks++;
      if (obs !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL reset cyc %0d tx/en/done/rdy got %b want 0001", i, obs);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      obs = {tx, tx_en, done, ready};
      exp = popExp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL idle cyc %0d tx/en/done/rdy got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_single_word();
    logic [3:0]   obs, exp;
    logic [W-1:0] rx = '0;
    int           nBits = 0;
    int           nEn = 0;
    int           nDone = 0;
    for (int i = 0; i < FRAME; i++) begin
      load = (i == 0);
      din = (i == 0) ? 8'hA5 : 8'h00;
      stepCycle();
      obs = {tx, tx_en, done, ready};
      exp = popExp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL single_word cyc %0d tx/en/done/rdy got %b want %b", i, obs, exp);
      end
      if (tx_en) begin
        if (nBits < W) rx[nBits] = tx;
        nBits++;
        nEn++;
      end
      if (done) nDone++;
    end
    checks++;
    if (rx !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_word_data got %h want a5", rx);
    end
    checks++;
    if (nDone != 1 || nEn != FRAME - 2) begin
      errors++;
      $display("[TB] FAIL single_word_counts done %0d en %0d want done 1 en %0d", nDone, nEn, FRAME - 2);
    end
  endtask

  task automatic test_load_ignored();
    logic [3:0]   obs, exp;
    logic [W-1:0] rx = '0;
    int           nBits = 0;
    int           nDone = 0;
    for (int i = 0; i < FRAME; i++) begin
      load = (i == 0) || (i >= 2 && i <= 5);
      din = (i == 0) ? 8'h3C : 8'hFF;
      stepCycle();
      obs = {tx, tx_en, done, ready};
      exp = popExp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL load_ignored cyc %0d tx/en/done/rdy got %b want %b", i, obs, exp);
      end
      if (tx_en && nBits < W) begin
        rx[nBits] = tx;
        nBits++;
      end
      if (done) nDone++;
    end
    load = 1'b0;
    checks++;
    if (rx !== 8'h3C || nDone != 1) begin
      errors++;
      $display("[TB] FAIL load_ignored_word got %h done %0d want 3c done 1", rx, nDone);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    logic       prevEn = 1'b0;
    int         starts[$];
    load = 1'b1;
    din = 8'h01;
    for (int i = 0; i < 3 * FRAME + 1; i++) begin
      if (i == 3 * FRAME) load = 1'b0;
      stepCycle();
      obs = {tx, tx_en, done, ready};
      exp = popExp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc %0d tx/en/done/rdy got %b want %b", i, obs, exp);
      end
      if (tx_en && !prevEn) starts.push_back(i);
      prevEn = tx_en;
    end
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("[TB] FAIL back_to_back_starts got %0d want 3", starts.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (starts[k] - starts[k-1] != FRAME) begin
          errors++;
          $display("[TB] FAIL back_to_back_period got %0d want %0d", starts[k] - starts[k-1], FRAME);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] obs, exp;
    int         nDone = 0;
    din = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      load = (i == 0);
      stepCycle();
      obs = {tx, tx_en, done, ready};
      exp = popExp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL mid_word cyc %0d tx/en/done/rdy got %b want %b", i, obs, exp);
      end
    end
    load = 1'b0;
    reset_n = 1'b0;
    stepCycle();
    obs = {tx, tx_en, done, ready};
    checks++;
    if (obs !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL mid_word_reset tx/en/done/rdy got %b want 0001", obs);
    end
    reset_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      stepCycle();
      obs = {tx, tx_en, done, ready};
      exp = popExp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL mid_word_after cyc %0d tx/en/done/rdy got %b want %b", i, obs, exp);
      end
      if (done) nDone++;
    end
    checks++;
    if (nDone != 0) begin
      errors++;
      $display("[TB] FAIL mid_word_no_done got %0d pulses want 0", nDone);
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [3:0]   obs, exp;
    logic [W-1:0] words[2] = '{8'h07, 8'hA5};
    logic         parWant[2] = '{1'b1, 1'b0};
    for (int w = 0; w < 2; w++) begin
      logic [W-1:0] rx = '0;
      logic         parGot = 1'bx;
      int           nEn = 0;
      int           doneAt = -1;
      for (int i = 0; i < FRAME; i++) begin
        load = (i == 0);
        din = words[w];
        stepCycle();
        obs = {tx, tx_en, done, ready};
        exp = popExp();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL parity_word%0d cyc %0d tx/en/done/rdy got %b want %b", w, i, obs, exp);
        end
        if (tx_en) begin
          if (nEn < W) rx[nEn] = tx;
          else parGot = tx;
          nEn++;
        end
        if (done && doneAt < 0) doneAt = i;
      end
      load = 1'b0;
      checks++;
      if (rx !== words[w] || parGot !== parWant[w]) begin
        errors++;
        $display("[TB] FAIL parity_bits word %h par %b want %h par %b", rx, parGot, words[w], parWant[w]);
      end
      checks++;
      if (doneAt != W + 1) begin
        errors++;
        $display("[TB] FAIL parity_done_time got %0d want %0d", doneAt, W + 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid_word();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
- Parallel-in/serial-out transmitter. It is the sending end for the enable-gated D flip-flop capture chain used by our serial receivers.
- It accepts a WIDTH-bit word on a load handshake and drives it out LSB-first, one bit per clock, on tx.
- tx_en is asserted for each valid bit, so a downstream DFF-with-enable can qualify its capture on it.
- It signals done for one cycle when the word completes, then returns to ready.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  reset; synchronous and active-low
- load  input  1  request to transmit din; sampled only when ready=1
- din  input  WIDTH  parallel word to send
- ready  output  1  block idle and able to accept load; combinational, equals (state==IDLE)
- tx  output  1  serial data bit, registered
- tx_en  output  1  tx holds a valid bit this cycle, registered
- done  output  1  one-cycle pulse after the last bit, registered

Behaviour:
- Reset: on a clk edge with reset_n=0, the block forces state=IDLE, tx=0, tx_en=0, done=0, shift register=0 and bit counter=0. ready=1 after that edge. Reset overrides everything, including mid-word; a partial word is abandoned with no done pulse.
- FSM states are IDLE, SHIFT and DONE.
- IDLE -> SHIFT at edge N when load=1 (ready=1 implied). At edge N:
  - din is captured into the shift register;
  - tx<=din[0] and tx_en<=1;
  - cnt<=1.
- SHIFT:
  - Each edge shifts right by one and drives the next bit. tx at edges N+k carries din[k], for k=0..WIDTH-1.
  - tx_en stays 1 through the cycle following edge N+WIDTH-1.
  - After the last data bit, at edge N+WIDTH: tx<=0, tx_en<=0, done<=1, state->DONE.
- DONE: at edge N+WIDTH+1, done<=0 and state->IDLE.
  - ready rises in the cycle after done; there is no back-to-back overlap.
  - Minimum word period is WIDTH+2 cycles.
- load while not ready (SHIFT or DONE) is ignored. It is not queued and has no effect on din capture.
- din is only sampled at the load edge; later changes to din do not affect the word in flight.
- Counter width is $clog2(WIDTH+2). The counter never wraps within a word and is cleared in IDLE.
- tx=0 whenever tx_en=0.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - After the last data bit, one extra bit (even parity, XOR of all din bits captured at load) is driven at edge N+WIDTH with tx_en=1.
  - done<=1 moves to edge N+WIDTH+1 and IDLE to edge N+WIDTH+2.
  - Word period becomes WIDTH+3.
- Undefined: no parity bit and no parity logic; timing is exactly as in Behaviour.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the counter width function.
- One natural sub-module: piso_shreg, a WIDTH-bit register with load and shift-enable inputs and bit-0 output.
- The FSM, counter and output registers stay in serial_tx_piso.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1 -> ready=1, tx=0, tx_en=0, done=0; holding load=0 for 5 cycles keeps all outputs unchanged.
- Single word, WIDTH=8, din=8'hA5 with load pulsed one cycle:
  - tx sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with tx_en=1;
  - then tx_en=0 and done=1 for exactly 1 cycle;
  - ready=1 the following cycle.
- Load ignored while busy: load din=8'h3C, then assert load with din=8'hFF during SHIFT -> serial output is still 0,0,1,1,1,1,0,0 and only one done pulse occurs; din change after load has no effect.
- Back-to-back: hold load=1 continuously with din=8'h01 -> words start every 10 cycles; each shows tx=1 on the first bit only.
- Reset mid-word: load 8'hF0, drive reset_n=0 at bit 3 -> next edge gives tx=0, tx_en=0, done=0, ready=1; no done pulse follows.
- Parity build (SERIAL_TX_PARITY_EN defined), din=8'h07 -> 1,1,1,0,0,0,0,0 then parity bit 1 with tx_en=1; done pulses 9 cycles after load. With din=8'hA5 the parity bit is 0.
